// File: rtl/fp_cvt_arbiter.sv
// Round-robin arbiter sharing one fixed-latency float-to-int converter, with a
// credit-protected result FIFO. Optional FP_CVT_SATURATE_EN clamps overflowing results.
module fp_cvt_arbiter #(
  parameter  int NUM_REQ    = 4,
  parameter  int LATENCY    = 3,
  parameter  int FIFO_DEPTH = 5,
  localparam int IDW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CW         = $clog2(FIFO_DEPTH + 1),
  localparam int AW         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1,
  localparam int EW         = 32 + IDW + 1
) (
  input  logic                      clk,
  input  logic                      areset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [32*NUM_REQ-1:0]     req_data,
  input  logic [NUM_REQ-1:0]        req_signed,
  output logic [31:0]               cvt_a,
  input  logic signed [32:0]        cvt_q,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [31:0]               resp_data,
  output logic [IDW-1:0]            resp_id,
  output logic                      resp_overflow
);

  function automatic logic range_ovf(input logic signed [32:0] q, input logic sgn);
    return sgn ? (q[32] ^ q[31]) : q[32];
  endfunction

`ifdef FP_CVT_SATURATE_EN
  function automatic logic [31:0] sat_clamp(input logic sgn, input logic neg);
    return sgn ? (neg ? 32'h8000_0000 : 32'h7FFF_FFFF) : 32'h0000_0000;
  endfunction
`endif

  function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
    return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [CW-1:0]      used_q, used_d;
  logic               gnt_vld;
  logic [IDW-1:0]     gnt_id;
  int                 idx;

  logic [LATENCY-1:0] tag_vld_q;
  logic [LATENCY-1:0] tag_sgn_q;
  logic [IDW-1:0]     tag_id_q [LATENCY];
`ifdef FP_CVT_SATURATE_EN
  logic [LATENCY-1:0] tag_neg_q;
`endif

  logic [EW-1:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]      wr_q, rd_q;
  logic [CW-1:0]      cnt_q;
  logic               push, pop, push_ovf;
  logic [31:0]        push_data;

  // Arbitration: used_q counts FIFO entries plus in-flight conversions.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    idx     = 0;
    if (!areset && used_q < CW'(FIFO_DEPTH)) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = int'(ptr_q) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        if (!gnt_vld && req_valid[idx]) begin
          gnt_vld = 1'b1;
          gnt_id  = IDW'(idx);
        end
      end
    end
  end

  assign req_ready = gnt_vld ? (NUM_REQ'(1) << gnt_id) : '0;
  assign cvt_a     = gnt_vld ? req_data[32*gnt_id +: 32] : 32'h0;
  assign ptr_d     = gnt_vld ? ((gnt_id == IDW'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1) : ptr_q;

  assign resp_valid = (cnt_q != '0);
  assign pop        = resp_valid && resp_ready;
  assign push       = tag_vld_q[LATENCY-1];
  assign used_d     = used_q + CW'(gnt_vld) - CW'(pop);
  assign push_ovf   = range_ovf(cvt_q, tag_sgn_q[LATENCY-1]);

`ifdef FP_CVT_SATURATE_EN
  // Clamp direction follows the operand sign, since q may have wrapped past 33 bits.
  assign push_data = push_ovf ? sat_clamp(tag_sgn_q[LATENCY-1], tag_neg_q[LATENCY-1])
                              : cvt_q[31:0];
`else
  assign push_data = cvt_q[31:0];
`endif

  assign {resp_overflow, resp_id, resp_data} = resp_valid ? mem_q[rd_q] : '0;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      ptr_q     <= '0;
      used_q    <= '0;
      tag_vld_q <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
    end else begin
      ptr_q        <= ptr_d;
      used_q       <= used_d;
      tag_vld_q[0] <= gnt_vld;
      for (int k = 1; k < LATENCY; k++) tag_vld_q[k] <= tag_vld_q[k-1];
      if (push) wr_q <= wrap_inc(wr_q);
      if (pop)  rd_q <= wrap_inc(rd_q);
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end

  // Tag and FIFO payload: qualified by the valids above, so no reset needed.
  always_ff @(posedge clk) begin
    tag_id_q[0]  <= gnt_id;
    tag_sgn_q[0] <= req_signed[gnt_id];
`ifdef FP_CVT_SATURATE_EN
    tag_neg_q[0] <= cvt_a[31];
    for (int k = 1; k < LATENCY; k++) tag_neg_q[k] <= tag_neg_q[k-1];
`endif
    for (int k = 1; k < LATENCY; k++) begin
      tag_id_q[k]  <= tag_id_q[k-1];
      tag_sgn_q[k] <= tag_sgn_q[k-1];
    end
    if (push) mem_q[wr_q] <= {push_ovf, tag_id_q[LATENCY-1], push_data};
  end

endmodule

// File: tb/tb_fp_cvt_arbiter.sv
// Randomised bench for fp_cvt_arbiter with a latency-3 converter fixture and a
// transaction-level reference model (credits, round-robin, in-order results).
module tb_fp_cvt_arbiter;
  localparam int NR  = 4;
  localparam int LAT = 3;
  localparam int DEP = 5;
  localparam int IDW = 2;
  localparam longint S_MIN = -64'sd2147483648;
  localparam longint S_MAX = 64'sd2147483647;
  localparam longint U_MAX = 64'sd4294967295;

  logic                clk = 1'b0;
  logic                areset = 1'b0;
  logic [NR-1:0]       req_valid = '0;
  logic [NR-1:0]       req_ready;
  logic [32*NR-1:0]    req_data = '0;
  logic [NR-1:0]       req_signed = '0;
  logic [31:0]         cvt_a;
  logic signed [32:0]  cvt_q;
  logic                resp_valid;
  logic                resp_ready = 1'b0;
  logic [31:0]         resp_data;
  logic [IDW-1:0]      resp_id;
  logic                resp_overflow;

  fp_cvt_arbiter #(.NUM_REQ(NR), .LATENCY(LAT), .FIFO_DEPTH(DEP)) dut (
    .clk(clk), .areset(areset), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_signed(req_signed), .cvt_a(cvt_a), .cvt_q(cvt_q),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_id(resp_id), .resp_overflow(resp_overflow)
  );

  always #5 clk = ~clk;

  // Float to integer, truncating toward zero.
  function automatic longint f2i(input logic [31:0] f);
    int e;
    logic [63:0] mant, mag;
    e    = int'(f[30:23]) - 127;
    if (e < 0) return 0;
    mant = {40'd0, 1'b1, f[22:0]};
    if (e > 40)       mag = 64'h0000_01FF_FFFF_FFFF;
    else if (e >= 23) mag = mant << (e - 23);
    else              mag = mant >> (23 - e);
    return f[31] ? -longint'(mag) : longint'(mag);
  endfunction

  // Converter fixture: LAT-cycle pipeline on cvt_a.
  logic [31:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= cvt_a;
    for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign cvt_q = 33'(f2i(pipe[LAT-1]));

  typedef struct {
    int          id;
    logic [31:0] data;
    logic        ovf;
    int          rc;
  } exp_t;

  exp_t exp_q[$];
  int   mptr = 0, outst = 0, cyc = 0, gcount = 0;
  int   nvec = 0, nerr = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic void ref_result(input logic [31:0] f, input logic sgn,
                                     output logic [31:0] data, output logic ovf);
    longint v;
    v    = f2i(f);
    ovf  = sgn ? (v < S_MIN || v > S_MAX) : (v < 0 || v > U_MAX);
    data = v[31:0];
`ifdef FP_CVT_SATURATE_EN
    if (ovf) data = sgn ? ((v < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF) : 32'h0;
`endif
  endfunction

  function automatic logic [31:0] rand_float();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(120, 158)), 23'($urandom)};
  endfunction

  function automatic logic [32*NR-1:0] rand_ops();
    logic [32*NR-1:0] o;
    for (int i = 0; i < NR; i++) o[i*32 +: 32] = rand_float();
    return o;
  endfunction

  // One clock cycle: drive at negedge, check and advance the model just after.
  task automatic step(input logic [NR-1:0] v, input logic [32*NR-1:0] d,
                      input logic [NR-1:0] s, input logic rr, input logic rst);
    int g;
    logic exp_v;
    exp_t e;
    @(negedge clk);
    req_valid = v; req_data = d; req_signed = s; resp_ready = rr; areset = rst;
    #1;
    if (rst) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_fields", {resp_data, resp_id, resp_overflow}, 0);
      chk("rst_cvt_a", cvt_a, 0);
      exp_q.delete();
      mptr = 0;
      outst = 0;
    end else begin
      g = -1;
      if (outst < DEP)
        for (int k = 0; k < NR; k++)
          if (g < 0 && v[(mptr + k) % NR]) g = (mptr + k) % NR;
      chk("req_ready", req_ready, (g >= 0) ? (64'd1 << g) : 64'd0);
      chk("cvt_a", cvt_a, (g >= 0) ? d[g*32 +: 32] : 32'h0);
      exp_v = (exp_q.size() > 0) && (exp_q[0].rc <= cyc);
      chk("resp_valid", resp_valid, exp_v);
      if (exp_v) begin
        chk("resp_id", resp_id, exp_q[0].id);
        chk("resp_data", resp_data, exp_q[0].data);
        chk("resp_overflow", resp_overflow, exp_q[0].ovf);
        if (rr) begin
          void'(exp_q.pop_front());
          outst--;
        end
      end
      if (g >= 0) begin
        e.id = g;
        e.rc = cyc + LAT + 1;
        ref_result(d[g*32 +: 32], s[g], e.data, e.ovf);
        exp_q.push_back(e);
        mptr = (g + 1) % NR;
        outst++;
        gcount++;
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, '0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    logic [32*NR-1:0] d;
    #2 areset = 1'b1;
    step('0, '0, '0, 1'b0, 1'b1);
    step('1, rand_ops(), '1, 1'b0, 1'b1);
    idle(2);

    // single request from requester 2: 3.0 signed
    d = '0;
    d[2*32 +: 32] = 32'h4040_0000;
    step(4'b0100, d, 4'b0100, 1'b1, 1'b0);
    idle(8);

    // round-robin with everyone requesting
    gcount = 0;
    for (int i = 0; i < 24; i++) step('1, rand_ops(), 4'($urandom), 1'b1, 1'b0);
    chk("rr_grants", gcount, 24);
    idle(8);

    // backpressure: credits run out after DEP grants
    gcount = 0;
    for (int i = 0; i < 10; i++) step('1, rand_ops(), 4'($urandom), 1'b0, 1'b0);
    chk("bp_grants", gcount, DEP);
    step('1, rand_ops(), '0, 1'b1, 1'b0);
    gcount = 0;
    for (int i = 0; i < 11; i++) step('1, rand_ops(), 4'($urandom), 1'b1, 1'b0);
    chk("bp_resume", gcount, 11);
    idle(8);

    // overflow corners: 2^32 signed and -1.0 unsigned
    d = '0;
    d[0 +: 32]  = 32'h4F80_0000;
    d[32 +: 32] = 32'hBF80_0000;
    step(4'b0011, d, 4'b0001, 1'b1, 1'b0);
    step(4'b0010, d, 4'b0001, 1'b1, 1'b0);
    d[0 +: 32]  = 32'hCF80_0000;
    step(4'b0001, d, 4'b0000, 1'b1, 1'b0);
    idle(8);

    // random traffic
    for (int i = 0; i < 400; i++)
      step(4'($urandom), rand_ops(), 4'($urandom), ($urandom_range(0, 3) != 0), 1'b0);
    idle(10);
    chk("drain_random", exp_q.size(), 0);

    // reset with 3 in flight and 2 in the FIFO
    for (int i = 0; i < 5; i++) step('1, rand_ops(), '1, 1'b0, 1'b0);
    chk("pre_rst_outst", outst, 5);
    step('1, rand_ops(), '1, 1'b0, 1'b1);
    step('1, rand_ops(), '1, 1'b1, 1'b1);
    gcount = 0;
    d = rand_ops();
    step('1, d, '1, 1'b1, 1'b0);
    chk("post_rst_first", req_ready, 4'b0001);
    for (int i = 0; i < 12; i++) step('1, rand_ops(), 4'($urandom), 1'b1, 1'b0);
    idle(10);
    chk("drain_final", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
